// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the clock sequencer: mode encoding,
// default terminal counts and the count bus width.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2
   } mode_t;

   localparam int CNT_W        = 16;
   localparam int SEC_MAX_DEF  = 59;
   localparam int MIN_MAX_DEF  = 59;
   localparam int HOUR_MAX_DEF = 23;

endpackage

// File: rtl/tick_gen.sv
// Free-running clk divider: tick on the last cycle of each TICK_DIV period,
// half_tick twice per period (blink cadence); clr restarts the period.
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick,
   output logic half_tick
);

   localparam int DIV_W = $clog2(TICK_DIV);

   logic [DIV_W-1:0] div;

   assign tick      = (div == DIV_W'(TICK_DIV - 1));
   assign half_tick = tick || (div == DIV_W'(TICK_DIV / 2 - 1));

   // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst || clr) div <= '0;
      else if (tick)   div <= '0;
      else             div <= div + 1'b1;
   end

endmodule

// File: rtl/clock_seq_ctrl.sv
// Strobe sequencer and RUN/SET_HOUR/SET_MIN mode FSM for the hh:mm:ss chain.
// Define CLOCK_SEQ_ALARM_EN to add the alarm comparator and its ports.
module clock_seq_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int SEC_MAX  = SEC_MAX_DEF,
   parameter int MIN_MAX  = MIN_MAX_DEF,
   parameter int HOUR_MAX = HOUR_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_mode,
   input  logic             btn_inc,
   input  logic [CNT_W-1:0] sec_cnt,
   input  logic [CNT_W-1:0] min_cnt,
   input  logic [CNT_W-1:0] hour_cnt,
`ifdef CLOCK_SEQ_ALARM_EN
   input  logic             alarm_on,
   input  logic [CNT_W-1:0] alarm_hour,
   input  logic [CNT_W-1:0] alarm_min,
   output logic             alarm,
`endif
   output logic             en_sec,
   output logic             en_min,
   output logic             en_hour,
   output logic [1:0]       mode,
   output logic             blink
);

   localparam logic [CNT_W-1:0] SEC_TERM  = CNT_W'(SEC_MAX);
   localparam logic [CNT_W-1:0] MIN_TERM  = CNT_W'(MIN_MAX);
   localparam logic [CNT_W-1:0] HOUR_TERM = CNT_W'(HOUR_MAX);

   mode_t mode_q, mode_d;
   logic  tick, half_tick, div_clr;
   logic  en_sec_d, en_min_d, en_hour_d, blink_d;
   logic  press_consumed, mode_adv, inc_req;

   // Hours wrap inside the hour counter itself; the terminal is kept for interface symmetry.
   logic  unused_cfg;
   assign unused_cfg = ^HOUR_TERM;

`ifdef CLOCK_SEQ_ALARM_EN
   logic alarm_q, alarm_d, alarm_hit;

   assign alarm_hit      = (hour_cnt == alarm_hour) && (min_cnt == alarm_min) && (sec_cnt == '0);
   assign press_consumed = alarm_q && (btn_mode || btn_inc);
   assign alarm          = alarm_q;

   always_comb begin
      alarm_d = alarm_q;
      if (!alarm_on)                                alarm_d = 1'b0;
      else if (press_consumed)                      alarm_d = 1'b0;
      else if (mode_q == MODE_RUN && alarm_hit)     alarm_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) alarm_q <= 1'b0;
      else      alarm_q <= alarm_d;
   end
`else
   logic unused_hour;
   assign unused_hour    = ^hour_cnt;
   assign press_consumed = 1'b0;
`endif

   // A press that silences the alarm does nothing else; mode beats inc.
   assign mode_adv = btn_mode && !press_consumed;
   assign inc_req  = btn_inc && !btn_mode && !press_consumed;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .clr       (div_clr),
      .tick      (tick),
      .half_tick (half_tick)
   );

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      mode_d    = mode_q;
      en_sec_d  = 1'b0;
      en_min_d  = 1'b0;
      en_hour_d = 1'b0;
      blink_d   = blink;
      div_clr   = 1'b0;
      unique case (mode_q)
         MODE_RUN: begin
            blink_d = 1'b0;
            if (mode_adv) begin
               mode_d  = MODE_SET_HOUR;
               blink_d = 1'b1;
            end else if (tick) begin
               en_sec_d  = 1'b1;
               en_min_d  = (sec_cnt == SEC_TERM);
               en_hour_d = (sec_cnt == SEC_TERM) && (min_cnt == MIN_TERM);
            end
         end
         MODE_SET_HOUR: begin
            if (mode_adv) begin
               mode_d  = MODE_SET_MIN;
               blink_d = 1'b1;
            end else begin
               en_hour_d = inc_req && !en_hour;
               if (half_tick) blink_d = !blink;
            end
         end
         MODE_SET_MIN: begin
            if (mode_adv) begin
               mode_d  = MODE_RUN;
               blink_d = 1'b0;
               div_clr = 1'b1;
            end else begin
               en_min_d = inc_req && !en_min;
               if (half_tick) blink_d = !blink;
            end
         end
         default: begin
            mode_d  = MODE_RUN;
            blink_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q  <= MODE_RUN;
         en_sec  <= 1'b0;
         en_min  <= 1'b0;
         en_hour <= 1'b0;
         blink   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         en_sec  <= en_sec_d;
         en_min  <= en_min_d;
         en_hour <= en_hour_d;
         blink   <= blink_d;
      end
   end

   assign mode = mode_q;

endmodule

// File: tb/tb_clock_seq_ctrl.sv
// Randomized bench for clock_seq_ctrl with a cycle-level reference model of
// the clock's rules (tick period, cascade, mode walk, blink, set-mode strobes).
module tb_clock_seq_ctrl;

   localparam int TICK_DIV = 4;
   localparam int SEC_MAX  = 59;
   localparam int MIN_MAX  = 59;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_mode, btn_inc;
   logic [15:0] sec_cnt, min_cnt, hour_cnt;
   logic        en_sec, en_min, en_hour, blink;
   logic [1:0]  mode;
`ifdef CLOCK_SEQ_ALARM_EN
   logic        alarm_on = 1'b0;
   logic [15:0] alarm_hour = '0, alarm_min = '0;
   logic        alarm;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: cycles since the 1 s period last restarted, plus expected outputs.
   int m_cyc, m_mode;
   bit m_sec, m_min, m_hour, m_blink;

   always #5 clk = ~clk;

   clock_seq_ctrl #(.TICK_DIV(TICK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .sec_cnt    (sec_cnt),
      .min_cnt    (min_cnt),
      .hour_cnt   (hour_cnt),
`ifdef CLOCK_SEQ_ALARM_EN
      .alarm_on   (alarm_on),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .alarm      (alarm),
`endif
      .en_sec     (en_sec),
      .en_min     (en_min),
      .en_hour    (en_hour),
      .mode       (mode),
      .blink      (blink)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Advance the reference model by one clock given this cycle's inputs.
   task automatic model_step(input bit r, input bit bm, input bit bi,
                             input int s, input int m);
      bit tick, half, prev_min, prev_hour;
      tick      = (m_cyc % TICK_DIV) == TICK_DIV - 1;
      half      = (m_cyc % (TICK_DIV / 2)) == TICK_DIV / 2 - 1;
      prev_min  = m_min;
      prev_hour = m_hour;
      m_sec = 0; m_min = 0; m_hour = 0;
      if (!r) begin
         m_mode = 0; m_cyc = 0; m_blink = 0;
         return;
      end
      m_cyc++;
      if (bm) begin
         m_mode  = (m_mode + 1) % 3;
         m_blink = (m_mode != 0);
         if (m_mode == 0) m_cyc = 0;
      end else if (m_mode == 0) begin
         m_blink = 0;
         if (tick) begin
            m_sec  = 1;
            m_min  = (s == SEC_MAX);
            m_hour = (s == SEC_MAX) && (m == MIN_MAX);
         end
      end else begin
         if (half) m_blink = !m_blink;
         if (m_mode == 1) m_hour = bi && !prev_hour;
         else             m_min  = bi && !prev_min;
      end
   endtask

   // Drive one cycle of inputs at the falling edge, clock it, compare at the next falling edge.
   task automatic step(input bit r, input bit bm, input bit bi,
                       input int s, input int m, input int h);
      rst = r; btn_mode = bm; btn_inc = bi;
      sec_cnt = 16'(s); min_cnt = 16'(m); hour_cnt = 16'(h);
      model_step(r, bm, bi, s, m);
      @(posedge clk);
      @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0;
      check("en_sec",  32'(en_sec),  32'(m_sec));
      check("en_min",  32'(en_min),  32'(m_min));
      check("en_hour", 32'(en_hour), 32'(m_hour));
      check("mode",    32'(mode),    32'(m_mode));
      check("blink",   32'(blink),   32'(m_blink));
   endtask

   task automatic idle(input int n, input int s, input int m, input int h);
      for (int i = 0; i < n; i++) step(1, 0, 0, s, m, h);
   endtask

   initial begin
      rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      sec_cnt = '0; min_cnt = '0; hour_cnt = '0;
      m_cyc = 0; m_mode = 0; m_sec = 0; m_min = 0; m_hour = 0; m_blink = 0;
      @(negedge clk);

      // Reset state, then plain seconds ticking.
      step(0, 0, 0, 10, 0, 0);
      step(0, 0, 0, 10, 0, 0);
      idle(10, 10, 0, 0);

      // Full cascade at 05:59:59.
      idle(8, 59, 59, 5);

      // SET_HOUR: increment at hour=23 strobes only en_hour.
      step(1, 1, 0, 10, 0, 23);
      idle(2, 59, 59, 23);
      step(1, 0, 1, 59, 59, 23);
      idle(3, 59, 59, 23);

      // Simultaneous mode+inc: mode wins; then SET_MIN inc and return to RUN.
      step(1, 1, 1, 10, 0, 23);
      idle(3, 59, 59, 23);
      step(1, 0, 1, 10, 59, 23);
      idle(1, 10, 59, 23);
      step(1, 1, 0, 10, 59, 23);
      idle(6, 59, 10, 23);

      // Reset in the middle of SET_MIN with a pending inc.
      step(1, 1, 0, 10, 0, 0);
      step(1, 1, 0, 10, 0, 0);
      step(1, 0, 1, 10, 0, 0);
      step(0, 0, 0, 10, 0, 0);
      step(0, 0, 0, 10, 0, 0);
      idle(6, 10, 0, 0);

      // Corrupted counts are non-terminal.
      idle(8, 70, 99, 40);

      // Randomized traffic, biased toward terminal counts.
      for (int i = 0; i < 3000; i++) begin
         bit r, bm, bi;
         int s, m;
         r  = ($urandom_range(0, 99) != 0);
         bm = ($urandom_range(0, 9) == 0);
         bi = ($urandom_range(0, 4) == 0);
         s  = ($urandom_range(0, 2) == 0) ? SEC_MAX : int'($urandom_range(0, 70));
         m  = ($urandom_range(0, 2) == 0) ? MIN_MAX : int'($urandom_range(0, 70));
         step(r, bm, bi, s, m, int'($urandom_range(0, 25)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
